// File: rtl/axis_event_rx.sv
// AXI-Stream event receiver: splits {adc, ts} words onto a valid/ready event port and checks framing, TKEEP and timestamp order.
// Optional build macro EVT_RX_TS_CHECK_EN enables the strictly-increasing timestamp check.
module axis_event_rx #(
    parameter int ADC_W = 14,
    parameter int TS_W  = 50,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             cfg_enable,
    input  logic [CNT_W-1:0] cfg_packet_size,
    input  logic             cfg_clear,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ADC_W-1:0] evt_adc,
    output logic [TS_W-1:0]  evt_ts,
    output logic             evt_last,
    output logic [CNT_W-1:0] stat_pkt_cnt,
    output logic [CNT_W-1:0] stat_word_idx,
    output logic             stat_err_len,
    output logic             stat_err_keep,
    output logic             stat_err_ts
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_RESYNC = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] last_idx;
    logic             accept;
    logic             run_acc;
    logic             disable_req;
    logic             at_end;
    logic             frame_ok;
    logic             frame_short;
    logic             frame_long;

    assign n_eff    = (cfg_packet_size < CNT_W'(2)) ? CNT_W'(2) : cfg_packet_size;
    assign last_idx = n_eff - CNT_W'(1);

    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            ST_RUN:    s_axis_tready = ~evt_valid | evt_ready;
            ST_RESYNC: s_axis_tready = 1'b1;
            default:   s_axis_tready = 1'b0;
        endcase
    end

    assign accept      = s_axis_tvalid & s_axis_tready;
    assign run_acc     = accept & (state == ST_RUN);
    assign disable_req = (state != ST_IDLE) & ~cfg_enable;
    // A shrinking packet size can leave the index past the end; treat that as long too.
    assign at_end      = (stat_word_idx >= last_idx);
    assign frame_ok    = run_acc & s_axis_tlast & (stat_word_idx == last_idx);
    assign frame_short = run_acc & s_axis_tlast & (stat_word_idx != last_idx);
    assign frame_long  = run_acc & ~s_axis_tlast & at_end;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else if (disable_req) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (cfg_enable) state <= ST_RUN;
                ST_RUN:    if (frame_long) state <= ST_RESYNC;
                ST_RESYNC: if (accept && s_axis_tlast) state <= ST_RUN;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_word_idx <= '0;
        end else if (disable_req) begin
            stat_word_idx <= '0;
        end else if (run_acc) begin
            stat_word_idx <= (s_axis_tlast || at_end) ? '0 : stat_word_idx + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_pkt_cnt  <= '0;
            stat_err_len  <= 1'b0;
            stat_err_keep <= 1'b0;
        end else if (cfg_clear) begin
            stat_pkt_cnt  <= '0;
            stat_err_len  <= 1'b0;
            stat_err_keep <= 1'b0;
        end else begin
            if (frame_ok) stat_pkt_cnt <= stat_pkt_cnt + CNT_W'(1);
            if (frame_short || frame_long) stat_err_len <= 1'b1;
            if (run_acc && (s_axis_tkeep != 8'hFF)) stat_err_keep <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            evt_valid <= 1'b0;
            evt_adc   <= '0;
            evt_ts    <= '0;
            evt_last  <= 1'b0;
        end else if (run_acc) begin
            evt_valid <= 1'b1;
            evt_adc   <= s_axis_tdata[TS_W +: ADC_W];
            evt_ts    <= s_axis_tdata[TS_W-1:0];
            evt_last  <= s_axis_tlast;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

`ifdef EVT_RX_TS_CHECK_EN
    logic [TS_W-1:0] prev_ts;
    logic [TS_W-1:0] ts_delta;
    logic            have_prev;

    // Modular difference: forward steps below half range are legal, so counter wrap passes.
    assign ts_delta = s_axis_tdata[TS_W-1:0] - prev_ts;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            prev_ts     <= '0;
            have_prev   <= 1'b0;
            stat_err_ts <= 1'b0;
        end else begin
            if (cfg_clear)
                stat_err_ts <= 1'b0;
            else if (run_acc && have_prev && ((ts_delta == '0) || ts_delta[TS_W-1]))
                stat_err_ts <= 1'b1;
            if (cfg_clear || (state == ST_IDLE))
                have_prev <= 1'b0;
            else if (run_acc)
                have_prev <= 1'b1;
            if (run_acc) prev_ts <= s_axis_tdata[TS_W-1:0];
        end
    end
`else
    assign stat_err_ts = 1'b0;
`endif

endmodule

// File: tb/tb_axis_event_rx.sv
// Self-checking bench for axis_event_rx: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_axis_event_rx;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  s_axis_tkeep;
    logic        cfg_enable;
    logic [31:0] cfg_packet_size;
    logic        cfg_clear;
    logic        evt_valid;
    logic        evt_ready;
    logic [13:0] evt_adc;
    logic [49:0] evt_ts;
    logic        evt_last;
    logic [31:0] stat_pkt_cnt;
    logic [31:0] stat_word_idx;
    logic        stat_err_len;
    logic        stat_err_keep;
    logic        stat_err_ts;

`ifdef EVT_RX_TS_CHECK_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    axis_event_rx #(.ADC_W(14), .TS_W(50), .CNT_W(32)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
        .cfg_enable(cfg_enable), .cfg_packet_size(cfg_packet_size), .cfg_clear(cfg_clear),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_adc(evt_adc), .evt_ts(evt_ts), .evt_last(evt_last),
        .stat_pkt_cnt(stat_pkt_cnt), .stat_word_idx(stat_word_idx),
        .stat_err_len(stat_err_len), .stat_err_keep(stat_err_keep), .stat_err_ts(stat_err_ts)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [13:0] adc; logic [49:0] ts; logic last; } ev_t;
    ev_t         q[$];
    int          m_state;          // 0 idle, 1 run, 2 resync
    logic [31:0] m_pkt, m_idx;
    bit          m_elen, m_ekeep, m_ets, m_have;
    logic [49:0] m_prev;

    function automatic bit m_tready();
        if (m_state == 1) return (q.size() == 0) || evt_ready;
        if (m_state == 2) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rstn_i) begin
        bit          acc;
        int          old;
        logic [31:0] n;
        logic [49:0] d;
        ev_t         e;
        if (!rstn_i) begin
            q.delete();
            m_state = 0; m_pkt = 0; m_idx = 0;
            m_elen = 0; m_ekeep = 0; m_ets = 0; m_have = 0; m_prev = 0;
        end else begin
            acc = s_axis_tvalid && m_tready();
            old = m_state;
            if (q.size() > 0 && evt_ready) q.delete(0);
            n = (cfg_packet_size < 2) ? 32'd2 : cfg_packet_size;
            if (old == 0) begin
                m_have = 0;
                if (cfg_enable) m_state = 1;
            end else if (old == 1 && acc) begin
                e.adc = s_axis_tdata[63:50]; e.ts = s_axis_tdata[49:0]; e.last = s_axis_tlast;
                q.push_back(e);
                if (s_axis_tkeep != 8'hFF) m_ekeep = 1;
                if (TS_EN) begin
                    if (m_have) begin
                        d = e.ts - m_prev;
                        if (d == 0 || d >= (50'd1 << 49)) m_ets = 1;
                    end
                    m_prev = e.ts; m_have = 1;
                end
                if (s_axis_tlast) begin
                    if (m_idx == n - 1) m_pkt++; else m_elen = 1;
                    m_idx = 0;
                end else if (m_idx >= n - 1) begin
                    m_elen = 1; m_idx = 0; m_state = 2;
                end else begin
                    m_idx++;
                end
            end else if (old == 2 && acc && s_axis_tlast) begin
                m_state = 1;
            end
            if (old != 0 && !cfg_enable) begin
                m_state = 0; m_idx = 0;
            end
            if (cfg_clear) begin
                m_pkt = 0; m_elen = 0; m_ekeep = 0; m_ets = 0; m_have = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int          n_out = 0;
    logic [63:0] last_mask = '0;

    always @(negedge clk) begin
        check("tready", {63'd0, s_axis_tready}, {63'd0, m_tready()});
        check("evt_valid", {63'd0, evt_valid}, {63'd0, q.size() > 0});
        if (q.size() > 0) begin
            check("evt_adc", {50'd0, evt_adc}, {50'd0, q[0].adc});
            check("evt_ts", {14'd0, evt_ts}, {14'd0, q[0].ts});
            check("evt_last", {63'd0, evt_last}, {63'd0, q[0].last});
        end
        check("pkt_cnt", {32'd0, stat_pkt_cnt}, {32'd0, m_pkt});
        check("word_idx", {32'd0, stat_word_idx}, {32'd0, m_idx});
        check("flags", {61'd0, stat_err_len, stat_err_keep, stat_err_ts}, {61'd0, m_elen, m_ekeep, m_ets});
        if (evt_valid && evt_ready) begin
            if (evt_last && n_out < 64) last_mask[n_out] = 1'b1;
            n_out++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int k);
        repeat (k) begin @(posedge clk); #2; end
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1; step(1); cfg_clear = 1'b0;
    endtask

    task automatic send(input logic [49:0] ts, input logic lst, input logic [7:0] keep);
        bit a;
        s_axis_tdata  = {14'($urandom), ts};
        s_axis_tlast  = lst;
        s_axis_tkeep  = keep;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); a = s_axis_tready;
            @(posedge clk); #2;
            if (a) break;
            if (i == 199) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout ts=%0h never accepted", ts);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tkeep  = 8'hFF;
    endtask

    int          base;
    logic [49:0] rts;

    initial begin
        rstn_i = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tkeep = 8'hFF; cfg_enable = 1'b0; cfg_packet_size = 32'd4; cfg_clear = 1'b0;
        evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tready", {63'd0, s_axis_tready}, 64'd0);
        check("rst_evt", {evt_valid, evt_adc, evt_ts, evt_last}, 64'd0);
        check("rst_stats", {stat_pkt_cnt, stat_word_idx}, 64'd0);
        check("rst_flags", {61'd0, stat_err_len, stat_err_keep, stat_err_ts}, 64'd0);
        @(posedge clk); #2; rstn_i = 1'b1; cfg_enable = 1'b1; step(2);

        // three clean 4-word packets
        n_out = 0; last_mask = '0;
        for (int unsigned i = 1; i <= 12; i++) send(50'(i * 8), (i % 4) == 0, 8'hFF);
        step(3); @(negedge clk);
        check("t1_events", 64'(n_out), 64'd12);
        check("t1_lastpos", last_mask, 64'h888);
        check("t1_pkt", {32'd0, stat_pkt_cnt}, 64'd3);
        check("t1_flags", {61'd0, stat_err_len, stat_err_keep, stat_err_ts}, 64'd0);
        step(1);

        // consumer stall mid-stream
        base = n_out;
        fork
            for (int unsigned i = 0; i < 8; i++) send(50'(200 + i * 4), (i % 4) == 3, 8'hFF);
            begin step(2); evt_ready = 1'b0; step(5); evt_ready = 1'b1; end
        join
        step(3); @(negedge clk);
        check("t2_no_loss", 64'(n_out - base), 64'd8);
        step(1);

        // short packet then a good one
        pulse_clear();
        send(50'd300, 1'b0, 8'hFF); send(50'd308, 1'b1, 8'hFF);
        step(2); @(negedge clk);
        check("t3_errlen", {63'd0, stat_err_len}, 64'd1);
        check("t3_idx", {32'd0, stat_word_idx}, 64'd0);
        step(1);
        for (int unsigned i = 0; i < 4; i++) send(50'(320 + i * 8), i == 3, 8'hFF);
        step(2); @(negedge clk);
        check("t3_pkt", {32'd0, stat_pkt_cnt}, 64'd1);
        step(1);

        // long packet: 7 words, tlast on the 7th
        pulse_clear(); base = n_out;
        for (int unsigned i = 0; i < 7; i++) send(50'(400 + i * 8), i == 6, 8'hFF);
        step(3); @(negedge clk);
        check("t4_errlen", {63'd0, stat_err_len}, 64'd1);
        check("t4_delivered", 64'(n_out - base), 64'd4);
        step(1);
        for (int unsigned i = 0; i < 4; i++) send(50'(500 + i * 8), i == 3, 8'hFF);
        step(2); @(negedge clk);
        check("t4_pkt_after", {32'd0, stat_pkt_cnt}, 64'd1);
        step(1);

        // timestamp wrap and repeat
        pulse_clear(); cfg_packet_size = 32'd2;
        send(50'h3_FFFF_FFFF_FFF8, 1'b0, 8'hFF); send(50'd0, 1'b1, 8'hFF);
        step(2); @(negedge clk);
        check("t5_wrap_ok", {63'd0, stat_err_ts}, 64'd0);
        step(1);
        send(50'd40, 1'b0, 8'hFF); send(50'd40, 1'b1, 8'hFF);
        step(2); @(negedge clk);
        check("t5_repeat", {63'd0, stat_err_ts}, {63'd0, TS_EN});
        step(1);

        // clear coincides with new keep/ts errors
        pulse_clear();
        send(50'd700, 1'b0, 8'hFF);
        s_axis_tdata = {14'd5, 50'd700}; s_axis_tlast = 1'b1; s_axis_tkeep = 8'h0F;
        s_axis_tvalid = 1'b1; cfg_clear = 1'b1;
        step(1);
        s_axis_tvalid = 1'b0; cfg_clear = 1'b0; s_axis_tkeep = 8'hFF;
        step(2); @(negedge clk);
        check("t6_clear_prio", {61'd0, stat_err_len, stat_err_keep, stat_err_ts}, 64'd0);
        step(1);

        // bad tkeep still delivered
        base = n_out;
        send(50'd800, 1'b0, 8'h0F); send(50'd808, 1'b1, 8'hFF);
        step(2); @(negedge clk);
        check("t7_keep", {63'd0, stat_err_keep}, 64'd1);
        check("t7_delivered", 64'(n_out - base), 64'd2);
        step(1);

        // randomized traffic
        rts = 50'd1000;
        for (int unsigned c = 0; c < 3000; c++) begin
            s_axis_tvalid = ($urandom % 4) != 0;
            evt_ready     = ($urandom % 4) != 0;
            s_axis_tlast  = ($urandom % 5) == 0;
            s_axis_tkeep  = (($urandom % 30) == 0) ? 8'h0F : 8'hFF;
            rts           = rts + 50'((($urandom % 16) == 0) ? 0 : 1 + ($urandom % 50));
            s_axis_tdata  = {14'($urandom), rts};
            cfg_clear     = ($urandom % 40) == 0;
            if (($urandom % 60) == 0) cfg_packet_size = $urandom % 6;
            if (!s_axis_tvalid && ($urandom % 100) == 0) cfg_enable = ~cfg_enable;
            step(1);
        end
        s_axis_tvalid = 1'b0; cfg_clear = 1'b0; cfg_enable = 1'b1; evt_ready = 1'b1;
        cfg_packet_size = 32'd4; step(4);

        // asynchronous reset mid-packet with a held event
        evt_ready = 1'b0;
        send(50'hA000, 1'b0, 8'hFF);
        @(posedge clk); #3; rstn_i = 1'b0; #1;
        check("arst_tready", {63'd0, s_axis_tready}, 64'd0);
        check("arst_evt", {evt_valid, evt_adc, evt_ts, evt_last}, 64'd0);
        check("arst_stats", {stat_pkt_cnt, stat_word_idx}, 64'd0);
        check("arst_flags", {61'd0, stat_err_len, stat_err_keep, stat_err_ts}, 64'd0);
        step(2); rstn_i = 1'b1; evt_ready = 1'b1; step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
